div_unit: RTL and testbench

Multi-cycle radix-2 restoring divider serving the EX-stage ALU for DIV/DIVU. It responds to the ALU's start_div/signed_div request and returns ready plus a 64-bit {remainder, quotient} word in HI/LO layout. The pipeline holds stall_div (generated outside this block) while start_div=1 and ready=0. annul cancels an in-flight divide on exception or flush.

---
 rtl/div_unit.sv | 161 ++++++++++++++++
 tb/tb_div_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in the EX stage.
// Returns {remainder, quotient} after WIDTH iterations, or at once for divide-by-zero.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start_div,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   input  logic               annul,
   output logic [2*WIDTH-1:0] result,
   output logic               ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ZERO,
      S_ON,
      S_END
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     dvd_q, dvd_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic                 sgn_q, sgn_d;
   logic                 dneg_q, dneg_d;
   logic                 qneg_q, qneg_d;
   logic                 ready_q, ready_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic [WIDTH:0]       shifted;
   logic [WIDTH:0]       diff;
   logic                 qbit;
   logic [WIDTH-1:0]     rem_nxt;
   logic [WIDTH-1:0]     quo_nxt;
   logic [WIDTH-1:0]     rem_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     abs1;
   logic [WIDTH-1:0]     abs2;
   logic                 last_iter;

   // One restoring step plus magnitude extraction and sign fix-up.
   always_comb begin
      shifted   = {rem_q, dvd_q[WIDTH-1]};
      diff      = shifted - {1'b0, dvs_q};
      qbit      = ~diff[WIDTH];
      rem_nxt   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_nxt   = {dvd_q[WIDTH-2:0], qbit};
      quo_fix   = (sgn_q && qneg_q) ? (~quo_nxt + 1'b1) : quo_nxt;
      rem_fix   = (sgn_q && dneg_q) ? (~rem_nxt + 1'b1) : rem_nxt;
      abs1      = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
      abs2      = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
      last_iter = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Next-state and registered-output logic; annul takes priority everywhere.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      sgn_d    = sgn_q;
      dneg_d   = dneg_q;
      qneg_d   = qneg_q;
      ready_d  = ready_q;
      result_d = result_q;
      unique case (state_q)
         S_IDLE: begin
            ready_d  = 1'b0;
            result_d = '0;
            if (start_div && !annul) begin
               sgn_d  = signed_div;
               dneg_d = opdata1[WIDTH-1];
               qneg_d = opdata1[WIDTH-1] ^ opdata2[WIDTH-1];
               dvs_d  = abs2;
               rem_d  = '0;
               cnt_d  = '0;
               if (opdata2 == '0) begin
                  dvd_d   = opdata1;
                  state_d = S_ZERO;
               end else begin
                  dvd_d   = abs1;
                  state_d = S_ON;
               end
            end
         end
         S_ZERO: begin
            if (annul) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_END;
               ready_d  = 1'b1;
               result_d = {dvd_q, {WIDTH{1'b1}}};
            end
         end
         S_ON: begin
            if (annul) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_nxt;
               dvd_d = quo_nxt;
               cnt_d = cnt_q + 1'b1;
               if (last_iter) begin
                  state_d  = S_END;
                  ready_d  = 1'b1;
                  result_d = {rem_fix, quo_fix};
               end
            end
         end
         S_END: begin
            if (annul || !start_div) begin
               state_d  = S_IDLE;
               ready_d  = 1'b0;
               result_d = '0;
            end
         end
         default: begin
            state_d  = S_IDLE;
            ready_d  = 1'b0;
            result_d = '0;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         sgn_q    <= 1'b0;
         dneg_q   <= 1'b0;
         qneg_q   <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         sgn_q    <= sgn_d;
         dneg_q   <= dneg_d;
         qneg_q   <= qneg_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end

   assign ready  = ready_q;
   assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed DIV/DIVU vectors, latency,
// hold/release, annul and asynchronous reset behaviour.
module tb_div_unit;

   logic        clk;
   logic        resetn;
   logic        start_div;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int pass_cnt;
   int total_cnt;

   logic [63:0] exp_q[$];
   string       name_q[$];
   logic        rdy_prev;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start_div  (start_div),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .annul      (annul),
      .result     (result),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm,
                      input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: compare result against the scoreboard on each rising ready.
   always @(negedge clk) begin
      if (ready && !rdy_prev) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_ready", result, 64'h0);
         end else begin
            automatic logic [63:0] e = exp_q.pop_front();
            automatic string n = name_q.pop_front();
            chk(result === e, n, result, e);
         end
      end
      rdy_prev = ready;
   end

   task automatic do_div(input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int lat, input int hold, input string nm);
      int n;
      @(posedge clk); #1;
      start_div  = 1'b1;
      signed_div = sg;
      opdata1    = a;
      opdata2    = b;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk); #1;
      opdata1    = 32'hDEADBEEF;
      opdata2    = 32'h0;
      signed_div = ~sg;
      n = 0;
      while (!ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(n == lat, {nm, "_latency"}, 64'(n), 64'(lat));
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         chk(ready === 1'b1 && result === exp, {nm, "_hold"}, result, exp);
      end
      start_div = 1'b0;
      @(posedge clk); #1;
      chk({ready, result} === 65'h0, {nm, "_release"},
          {ready, result[62:0]}, 64'h0);
   endtask

   initial begin
      int seen;
      pass_cnt   = 0;
      total_cnt  = 0;
      rdy_prev   = 1'b0;
      resetn     = 1'b0;
      start_div  = 1'b0;
      signed_div = 1'b0;
      opdata1    = '0;
      opdata2    = '0;
      annul      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({ready, result} === 65'h0, "reset_state", {ready, result[62:0]}, 64'h0);
      resetn = 1'b1;

      do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32, 5, "divu_100_7");
      do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 32, 0, "div_m7_2");
      do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 32, 0, "div_7_m2");
      do_div(1'b0, 32'hFFFFFFFF, 32'd2, 64'h00000001_7FFFFFFF, 32, 0, "divu_max_2");
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32, 0, "div_ovf");
      do_div(1'b0, 32'h00001234, 32'd0, 64'h00001234_FFFFFFFF, 1, 2, "div_by_zero");
      do_div(1'b0, 32'd5, 32'd10, 64'h00000005_00000000, 32, 0, "divu_5_10");
      do_div(1'b0, 32'd0, 32'd5, 64'h0, 32, 0, "divu_0_5");

      // Annul at iteration 10 with start still held.
      @(posedge clk); #1;
      start_div = 1'b1; signed_div = 1'b0;
      opdata1 = 32'd1000; opdata2 = 32'd3;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      annul = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready) seen++;
      end
      chk(seen == 0, "annul_no_ready", 64'(seen), 64'h0);
      annul = 1'b0;
      start_div = 1'b0;
      do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 0, "divu_9_3");

      // Asynchronous reset mid-operation.
      @(posedge clk); #1;
      start_div = 1'b1; signed_div = 1'b0;
      opdata1 = 32'd77; opdata2 = 32'd4;
      @(posedge clk); #1;
      repeat (20) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk({ready, result} === 65'h0, "reset_mid_op", {ready, result[62:0]}, 64'h0);
      start_div = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      do_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 32, 0, "divu_50_5");

      // Asynchronous reset while a result is being held.
      exp_q.push_back(64'h00000000_00000007);
      name_q.push_back("divu_49_7");
      @(posedge clk); #1;
      start_div = 1'b1; signed_div = 1'b0;
      opdata1 = 32'd49; opdata2 = 32'd7;
      repeat (36) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk({ready, result} === 65'h0, "reset_in_end", {ready, result[62:0]}, 64'h0);
      start_div = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;

      repeat (3) @(posedge clk);
      chk(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
